// File: rtl/jam_cost_rom_pkg.sv
// Shared definitions for the job-assignment cost table: FSM encoding and table geometry.
package jam_cost_rom_pkg;

  localparam int COST_W_DEF  = 7;
  localparam int N_IDX       = 8;
  localparam int IDX_W       = 3;
  localparam int TABLE_DEPTH = 64;
  localparam int ADDR_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

endpackage

// File: rtl/jam_perm_checker.sv
// Watches W/J lookups in SERVE and flags any job index reused within one W=0..7 sweep.
module jam_perm_checker
  import jam_cost_rom_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             active,
  input  logic [IDX_W-1:0] W,
  input  logic [IDX_W-1:0] J,
  output logic             perm_err,
  output logic [15:0]      perm_cnt
);

  logic [N_IDX-1:0] mask;
  logic [IDX_W-1:0] prev_w;
  logic             win_valid;
  logic             started;
  logic [N_IDX-1:0] j_bit;
  logic             w_start;
  logic             w_hold;
  logic             w_step;

  assign j_bit   = {{(N_IDX-1){1'b0}}, 1'b1} << J;
  assign w_start = (W == '0) && ((prev_w != '0) || !started);
  assign w_hold  = (W == prev_w);
  // Compare in one extra bit so prev_w=7 never looks like a step to W=0.
  assign w_step  = win_valid && ({1'b0, W} == ({1'b0, prev_w} + 4'd1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mask      <= '0;
      prev_w    <= '0;
      win_valid <= 1'b0;
      started   <= 1'b0;
      perm_err  <= 1'b0;
      perm_cnt  <= '0;
    end else if (active) begin
      started <= 1'b1;
      prev_w  <= W;
      if (w_start) begin
        mask      <= j_bit;
        win_valid <= 1'b1;
      end else if (w_hold) begin
        mask <= mask;
      end else if (w_step) begin
        if ((mask & j_bit) != '0) perm_err <= 1'b1;
        mask <= mask | j_bit;
        if (W == IDX_W'(N_IDX - 1)) begin
          perm_cnt  <= perm_cnt + 16'd1;
          win_valid <= 1'b0;
        end
      end else begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jam_cost_rom.sv
// Loadable 8x8 worker/job cost table with registered lookup and a permutation checker.
module jam_cost_rom
  import jam_cost_rom_pkg::*;
#(
  parameter int COST_W = COST_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic              load_en,
  input  logic [COST_W-1:0] load_data,
  output logic              load_ready,
  output logic              table_ready,
  output logic              perm_err,
  output logic [15:0]       perm_cnt,
  output logic [1:0]        dbg_state
);

  // Load handshake: an entry transfers on every rising edge where load_en and load_ready
  // are both high; load_ready never drops mid-load, so load_en alone paces the stream.
  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic              tbl_we;
  logic [COST_W-1:0] tbl [TABLE_DEPTH];

  assign dbg_state = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    wr_addr     = addr;
    tbl_we      = 1'b0;
    load_ready  = 1'b0;
    table_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        wr_addr    = '0;
        if (load_en) begin
          tbl_we    = 1'b1;
          addr_nxt  = ADDR_W'(1);
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_en) begin
          tbl_we   = 1'b1;
          addr_nxt = addr + ADDR_W'(1);
          if (addr == ADDR_W'(TABLE_DEPTH - 1)) state_nxt = ST_SERVE;
        end
      end
      ST_SERVE: begin
        table_ready = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        addr_nxt  = '0;
      end
    endcase
  end

  // Plain storage with no reset so it maps onto RAM or flops without a clear network.
  always_ff @(posedge CLK) begin
    if (tbl_we) tbl[wr_addr] <= load_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Cost <= '0;
    end else if (state == ST_SERVE) begin
      Cost <= tbl[{W, J}];
    end else begin
      Cost <= '0;
    end
  end

  jam_perm_checker u_perm_checker (
    .CLK      (CLK),
    .RST      (RST),
    .active   (state == ST_SERVE),
    .W        (W),
    .J        (J),
    .perm_err (perm_err),
    .perm_cnt (perm_cnt)
  );

endmodule

// File: tb/tb_jam_cost_rom.sv
// Self-checking bench for jam_cost_rom: directed scenarios plus randomized load/lookup traffic.
module tb_jam_cost_rom;

  localparam int CW = 7;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [2:0]    W = '0;
  logic [2:0]    J = '0;
  logic [CW-1:0] Cost;
  logic          load_en = 1'b0;
  logic [CW-1:0] load_data = '0;
  logic          load_ready;
  logic          table_ready;
  logic          perm_err;
  logic [15:0]   perm_cnt;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: table contents, number of accepted entries, and the jobs seen so far
  // in the current worker sweep.
  logic [CW-1:0] m_tbl [64];
  int            m_wr;
  logic [CW-1:0] m_cost;
  bit            m_err;
  int            m_cnt;
  int            m_jobs[$];
  bit            m_open;
  int            m_prev_w;
  bit            m_seen;

  always #5 CLK = ~CLK;

  jam_cost_rom #(.COST_W(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .W           (W),
    .J           (J),
    .Cost        (Cost),
    .load_en     (load_en),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .table_ready (table_ready),
    .perm_err    (perm_err),
    .perm_cnt    (perm_cnt),
    .dbg_state   (dbg_state)
  );

  task automatic model_reset();
    m_wr = 0; m_cost = '0; m_err = 0; m_cnt = 0;
    m_jobs.delete(); m_open = 0; m_prev_w = 0; m_seen = 0;
  endtask

  task automatic model_edge(input logic le, input logic [CW-1:0] ld, input int w, input int j);
    if (m_wr == 64) begin
      m_cost = m_tbl[w*8 + j];
      if (w == 0 && (m_prev_w != 0 || !m_seen)) begin
        m_jobs.delete();
        m_jobs.push_back(j);
        m_open = 1;
      end else if (w == m_prev_w) begin
        m_open = m_open;
      end else if (m_open && w == m_prev_w + 1) begin
        foreach (m_jobs[k]) if (m_jobs[k] == j) m_err = 1;
        m_jobs.push_back(j);
        if (m_jobs.size() == 8) begin
          m_cnt  = (m_cnt + 1) % 65536;
          m_open = 0;
        end
      end else begin
        m_open = 0;
      end
      m_prev_w = w;
      m_seen   = 1;
    end else begin
      m_cost = '0;
      if (le) begin
        m_tbl[m_wr] = ld;
        m_wr++;
      end
    end
  endtask

  task automatic step(input logic le, input logic [CW-1:0] ld, input logic [2:0] w, input logic [2:0] j);
    load_en = le; load_data = ld; W = w; J = j;
    @(posedge CLK);
    model_edge(le, ld, int'(w), int'(j));
    #1;
  endtask

  task automatic reset_dut();
    load_en = 1'b0; load_data = '0; W = '0; J = '0;
    RST = 1'b1;
    #7;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    n_cmp += 5;
    if (load_ready !== 1'b1) begin n_bad++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
    if (table_ready !== 1'b0) begin n_bad++; $display("FAIL reset_table_ready: got %b want 0", table_ready); end
    if (Cost !== '0) begin n_bad++; $display("FAIL reset_cost: got %0d want 0", Cost); end
    if (perm_err !== 1'b0) begin n_bad++; $display("FAIL reset_perm_err: got %b want 0", perm_err); end
    if (perm_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_perm_cnt: got %0d want 0", perm_cnt); end
  endtask

  task automatic load_index_table();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, CW'(i % 128), 3'd0, 3'd0);
      n_cmp += 2;
      if (table_ready !== (i == 63)) begin
        n_bad++; $display("FAIL load_table_ready @%0d: got %b want %b", i, table_ready, (i == 63));
      end
      if (load_ready !== (i != 63)) begin
        n_bad++; $display("FAIL load_load_ready @%0d: got %b want %b", i, load_ready, (i != 63));
      end
    end
    step(1'b0, '0, 3'd3, 3'd5);
    n_cmp++;
    if (Cost !== CW'(29)) begin n_bad++; $display("FAIL lookup_3_5: got %0d want 29", Cost); end
  endtask

  task automatic test_load_continuous();
    load_index_table();
  endtask

  task automatic test_perm_clean();
    for (int w = 0; w < 8; w++) begin
      step(1'b0, '0, 3'(w), 3'(7 - w));
      n_cmp++;
      if (Cost !== CW'(7*w + 7)) begin n_bad++; $display("FAIL clean_cost w=%0d: got %0d want %0d", w, Cost, 7*w + 7); end
    end
    repeat (3) step(1'b0, '0, 3'd7, 3'd0);
    n_cmp += 2;
    if (perm_cnt !== 16'd1) begin n_bad++; $display("FAIL clean_perm_cnt: got %0d want 1", perm_cnt); end
    if (perm_err !== 1'b0) begin n_bad++; $display("FAIL clean_perm_err: got %b want 0", perm_err); end
  endtask

  task automatic test_perm_err();
    int jobs[3] = '{4, 1, 4};
    for (int w = 0; w < 3; w++) begin
      step(1'b0, '0, 3'(w), 3'(jobs[w]));
      n_cmp++;
      if (perm_err !== (w == 2)) begin n_bad++; $display("FAIL err_flag w=%0d: got %b want %b", w, perm_err, (w == 2)); end
    end
    for (int w = 3; w < 8; w++) step(1'b0, '0, 3'(w), 3'(w));
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < 8; w++) step(1'b0, '0, 3'(w), 3'((w + r + 1) % 8));
      n_cmp += 2;
      if (perm_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky r=%0d: got %b want 1", r, perm_err); end
      if (perm_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL err_perm_cnt r=%0d: got %0d want %0d", r, perm_cnt, m_cnt); end
    end
    n_cmp++;
    if (perm_cnt !== 16'd4) begin n_bad++; $display("FAIL err_total_cnt: got %0d want 4", perm_cnt); end
  endtask

  task automatic test_serve_ignores_load();
    step(1'b1, CW'(127), 3'd2, 3'd6);
    n_cmp++;
    if (Cost !== CW'(22)) begin n_bad++; $display("FAIL ignore_load_2_6: got %0d want 22", Cost); end
    for (int k = 0; k < 8; k++) begin
      int idx = $urandom_range(0, 63);
      step(1'b1, CW'(127), 3'(idx / 8), 3'(idx % 8));
      n_cmp += 2;
      if (Cost !== CW'(idx)) begin n_bad++; $display("FAIL ignore_load_cost idx=%0d: got %0d want %0d", idx, Cost, idx); end
      if (table_ready !== 1'b1) begin n_bad++; $display("FAIL ignore_load_ready: got %b want 1", table_ready); end
    end
  endtask

  task automatic test_reset_recovery();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        for (int i = 0; i < 30; i++) step(1'b1, CW'($urandom), 3'd0, 3'd0);
      end
      RST = 1'b1;
      #2;
      n_cmp += 5;
      if (load_ready !== 1'b1) begin n_bad++; $display("FAIL rst%0d_load_ready: got %b want 1", pass, load_ready); end
      if (table_ready !== 1'b0) begin n_bad++; $display("FAIL rst%0d_table_ready: got %b want 0", pass, table_ready); end
      if (Cost !== '0) begin n_bad++; $display("FAIL rst%0d_cost: got %0d want 0", pass, Cost); end
      if (perm_cnt !== 16'd0) begin n_bad++; $display("FAIL rst%0d_perm_cnt: got %0d want 0", pass, perm_cnt); end
      if (perm_err !== 1'b0) begin n_bad++; $display("FAIL rst%0d_perm_err: got %b want 0", pass, perm_err); end
      model_reset();
      load_en = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
    end
    load_index_table();
  endtask

  task automatic test_toggle_load();
    reset_dut();
    for (int k = 0; k < 127; k++) begin
      step((k % 2) == 0, CW'(k / 2), 3'd0, 3'd0);
      n_cmp++;
      if (table_ready !== (k == 126)) begin
        n_bad++; $display("FAIL toggle_table_ready @%0d: got %b want %b", k, table_ready, (k == 126));
      end
    end
    step(1'b0, '0, 3'd7, 3'd7);
    n_cmp++;
    if (Cost !== CW'(63)) begin n_bad++; $display("FAIL toggle_lookup_7_7: got %0d want 63", Cost); end
  endtask

  task automatic test_random();
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] e;
    int plan_q[$];
    int perm[8];
    int guard, t, w, j, mode;
    reset_dut();
    guard = 0;
    while (m_wr < 64 && guard < 1000) begin
      step($urandom_range(0, 2) != 0, CW'($urandom), 3'($urandom), 3'($urandom));
      guard++;
      n_cmp++;
      if (load_ready !== (m_wr < 64) || table_ready !== (m_wr == 64) || Cost !== '0) begin
        n_bad++;
        $display("FAIL rand_load @%0d: load_ready=%b table_ready=%b Cost=%0d want %b %b 0",
                 guard, load_ready, table_ready, Cost, (m_wr < 64), (m_wr == 64));
      end
    end
    if (m_wr < 64) begin
      n_cmp++; n_bad++;
      $display("FAIL rand_load_timeout: accepted %0d want 64", m_wr);
    end
    for (int c = 0; c < 400; c++) begin
      if (plan_q.size() == 0) begin
        mode = $urandom_range(0, 5);
        if (mode <= 2) begin
          for (int k = 0; k < 8; k++) perm[k] = k;
          for (int k = 7; k > 0; k--) begin
            t = $urandom_range(0, k);
            w = perm[k]; perm[k] = perm[t]; perm[t] = w;
          end
          if (mode == 2) perm[$urandom_range(1, 7)] = perm[0];
          for (int k = 0; k < 8; k++) begin
            plan_q.push_back(k*8 + perm[k]);
            if ($urandom_range(0, 4) == 0) plan_q.push_back(k*8 + perm[k]);
          end
        end else if (mode == 3) begin
          repeat (4) plan_q.push_back($urandom_range(0, 63));
        end else begin
          w = $urandom_range(0, 7);
          repeat ($urandom_range(1, 3)) plan_q.push_back(w*8 + $urandom_range(0, 7));
        end
      end
      t = plan_q.pop_front();
      w = t / 8;
      j = t % 8;
      exp_q.push_back(m_tbl[t]);
      step($urandom_range(0, 1) == 1, CW'($urandom), 3'(w), 3'(j));
      e = exp_q.pop_front();
      n_cmp += 3;
      if (Cost !== e) begin n_bad++; $display("FAIL rand_cost c=%0d W=%0d J=%0d: got %0d want %0d", c, w, j, Cost, e); end
      if (perm_err !== m_err) begin n_bad++; $display("FAIL rand_perm_err c=%0d: got %b want %b", c, perm_err, m_err); end
      if (perm_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL rand_perm_cnt c=%0d: got %0d want %0d", c, perm_cnt, m_cnt); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_continuous();
    test_perm_clean();
    test_perm_err();
    test_serve_ignores_load();
    test_reset_recovery();
    test_toggle_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
